// File: rtl/ccd_acq_pkg.sv
// Shared types and defaults for the CCD acquisition sequencer.
// Holds the scan state enum, default parameters and the pixel-index width helper.
package ccd_acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROG,
        ST_READ,
        ST_WAIT
    } state_t;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_PIXELS     = 2048;
    localparam int DEF_DUMMY_PRE  = 32;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_ROG_CYCLES = 40;

    function automatic int pix_idx_w(input int dummy_pre, input int pixels);
        return ((dummy_pre + pixels) > 1) ? $clog2(dummy_pre + pixels) : 1;
    endfunction

endpackage

// File: rtl/ccd_acq_adc_cap.sv
// ADC capture: busy-fall detect, missed-convert check, optional correction (CCD_ACQ_CORR_EN), 1-entry output register.
// Capture to pix_valid is 1 cycle raw / 2 corrected; a capture into a full stalled register is dropped and flagged.
module ccd_acq_adc_cap
    import ccd_acq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              clr_ovr,
    input  logic              cvt,
    input  logic              cvt_keep,
    input  logic              cvt_last,
    input  logic              adc_busy,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] max_sat,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              overrun
);

    logic              armed;
    logic              seen;
    logic              keep_q;
    logic              last_q;
    logic              cap;
    logic              cap_vld;
    logic              miss;
    logic              ld;
    logic              ld_last;
    logic              drop;
    logic [DATA_W-1:0] ld_dat;

    // busy is only looked at from the cycle after the convert pulse
    assign cap     = armed && seen && !adc_busy;
    assign cap_vld = cap && keep_q;
    assign miss    = cvt && armed && !cap && keep_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            armed  <= 1'b0;
            seen   <= 1'b0;
            keep_q <= 1'b0;
            last_q <= 1'b0;
        end else if (cvt) begin
            armed  <= 1'b1;
            seen   <= 1'b0;
            keep_q <= cvt_keep;
            last_q <= cvt_last;
        end else if (cap) begin
            armed <= 1'b0;
        end else if (armed && adc_busy) begin
            seen <= 1'b1;
        end
    end

`ifdef CCD_ACQ_CORR_EN
    logic              st_vld;
    logic              st_last;
    logic [DATA_W-1:0] st_dat;
    logic [DATA_W-1:0] clamped;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            st_vld  <= 1'b0;
            st_last <= 1'b0;
            st_dat  <= '0;
        end else begin
            st_vld  <= cap_vld;
            st_last <= last_q;
            st_dat  <= adc_data;
        end
    end

    // clamp before subtracting so saturated pixels land at max_sat - offset
    assign clamped = (st_dat > max_sat) ? max_sat : st_dat;
    assign ld      = st_vld;
    assign ld_dat  = (clamped > offset) ? (clamped - offset) : '0;
    assign ld_last = st_last;
`else
    logic unused_corr;
    assign unused_corr = ^{offset, max_sat};
    assign ld          = cap_vld;
    assign ld_dat      = adc_data;
    assign ld_last     = last_q;
`endif

    assign drop = ld && pix_valid && !pix_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_last  <= 1'b0;
        end else if (ld && !drop) begin
            pix_valid <= 1'b1;
            pix_data  <= ld_dat;
            pix_last  <= ld_last;
        end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr_ovr) begin
            overrun <= 1'b0;
        end else if (miss || drop) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/ccd_acq_seq.sv
// Linear-CCD scan sequencer (IDLE/ROG/READ/WAIT) driving ccd_clk, ROG and one ADC convert per pixel.
// Pixels stream over valid/ready; CCD_ACQ_CORR_EN adds clamp/dark-offset correction and one register stage.
module ccd_acq_seq
    import ccd_acq_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PIXELS     = DEF_PIXELS,
    parameter int DUMMY_PRE  = DEF_DUMMY_PRE,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int ROG_CYCLES = DEF_ROG_CYCLES
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              cont_en,
    input  logic              abort,
    input  logic [15:0]       int_time,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] max_sat,
    output logic              ccd_clk,
    output logic              ccd_rog,
    output logic              adc_convst,
    input  logic              adc_busy,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              overrun
);

    localparam int          N_PIX    = DUMMY_PRE + PIXELS;
    localparam int          IDX_W    = pix_idx_w(DUMMY_PRE, PIXELS);
    localparam int          DIV_W    = $clog2(CLK_DIV);
    localparam logic [31:0] WAIT_MUL = 32'(2 * CLK_DIV);

    state_t           state;
    logic [31:0]      cnt;
    logic [31:0]      wait_len;
    logic [31:0]      next_wait;
    logic [DIV_W-1:0] dcnt;
    logic [IDX_W-1:0] idx;
    logic             cont_q;
    logic             cvt_keep;
    logic             cvt_last;
    logic             start_ok;

    assign start_ok  = (state == ST_IDLE) && start && !abort && !sys_rst;
    assign next_wait = {16'd0, int_time} * WAIT_MUL;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || abort) begin
            state      <= ST_IDLE;
            ccd_clk    <= 1'b1;
            ccd_rog    <= 1'b0;
            adc_convst <= 1'b0;
            scan_busy  <= 1'b0;
            scan_done  <= 1'b0;
            cnt        <= '0;
            wait_len   <= '0;
            dcnt       <= '0;
            idx        <= '0;
            cont_q     <= 1'b0;
            cvt_keep   <= 1'b0;
            cvt_last   <= 1'b0;
        end else begin
            adc_convst <= 1'b0;
            scan_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ROG;
                        ccd_rog   <= 1'b1;
                        scan_busy <= 1'b1;
                        cnt       <= '0;
                    end
                end
                ST_ROG: begin
                    if (cnt == 32'(ROG_CYCLES - 1)) begin
                        state   <= ST_READ;
                        ccd_rog <= 1'b0;
                        ccd_clk <= 1'b0;
                        dcnt    <= '0;
                        idx     <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_READ: begin
                    if (dcnt == DIV_W'(CLK_DIV - 1)) begin
                        dcnt <= '0;
                        if (!ccd_clk) begin
                            ccd_clk    <= 1'b1;
                            adc_convst <= 1'b1;
                            cvt_keep   <= (idx >= IDX_W'(DUMMY_PRE));
                            cvt_last   <= (idx == IDX_W'(N_PIX - 1));
                        end else if (idx == IDX_W'(N_PIX - 1)) begin
                            // end of readout: int_time and cont_en are latched here
                            scan_done <= 1'b1;
                            cnt       <= '0;
                            wait_len  <= next_wait;
                            cont_q    <= cont_en;
                            if (int_time != 16'd0) begin
                                state <= ST_WAIT;
                            end else if (cont_en) begin
                                state   <= ST_ROG;
                                ccd_rog <= 1'b1;
                            end else begin
                                state     <= ST_IDLE;
                                scan_busy <= 1'b0;
                            end
                        end else begin
                            ccd_clk <= 1'b0;
                            idx     <= idx + IDX_W'(1);
                        end
                    end else begin
                        dcnt <= dcnt + DIV_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == wait_len - 32'd1) begin
                        cnt <= '0;
                        if (cont_q) begin
                            state   <= ST_ROG;
                            ccd_rog <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            scan_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ccd_acq_adc_cap #(
        .DATA_W (DATA_W)
    ) u_cap (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .flush     (abort),
        .clr_ovr   (start_ok),
        .cvt       (adc_convst),
        .cvt_keep  (cvt_keep),
        .cvt_last  (cvt_last),
        .adc_busy  (adc_busy),
        .adc_data  (adc_data),
        .offset    (offset),
        .max_sat   (max_sat),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_ccd_acq_seq.sv
// Bench for ccd_acq_seq: ADC model returns index*100; expected pixels are queued and popped on each transfer.
module tb_ccd_acq_seq;

    localparam int DW   = 16;
    localparam int PIX  = 8;
    localparam int DUM  = 2;
    localparam int DIV  = 2;
    localparam int ROGC = 4;

    logic          sys_clk   = 1'b0;
    logic          sys_rst   = 1'b1;
    logic          start     = 1'b0;
    logic          cont_en   = 1'b0;
    logic          abort     = 1'b0;
    logic [15:0]   int_time  = 16'd0;
    logic [DW-1:0] offset    = 16'd250;
    logic [DW-1:0] max_sat   = 16'd700;
    logic          adc_busy  = 1'b0;
    logic [DW-1:0] adc_data  = '0;
    logic          pix_ready = 1'b1;
    logic          ccd_clk;
    logic          ccd_rog;
    logic          adc_convst;
    logic [DW-1:0] pix_data;
    logic          pix_last;
    logic          pix_valid;
    logic          scan_busy;
    logic          scan_done;
    logic          overrun;

    ccd_acq_seq #(
        .DATA_W     (DW),
        .PIXELS     (PIX),
        .DUMMY_PRE  (DUM),
        .CLK_DIV    (DIV),
        .ROG_CYCLES (ROGC)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .cont_en    (cont_en),
        .abort      (abort),
        .int_time   (int_time),
        .offset     (offset),
        .max_sat    (max_sat),
        .ccd_clk    (ccd_clk),
        .ccd_rog    (ccd_rog),
        .adc_convst (adc_convst),
        .adc_busy   (adc_busy),
        .adc_data   (adc_data),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .overrun    (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   rog_edges[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_cnt   = 0;
    int   valid_cyc  = 0;
    int   cyc        = 0;
    int   conv_idx   = 0;
    int   busy_cnt   = 0;
    bit   busy_stuck = 1'b0;
    bit   rog_prev   = 1'b0;

    function automatic logic [DW-1:0] exp_pix(input int raw);
`ifdef CCD_ACQ_CORR_EN
        int x;
        x = (raw > 700) ? 700 : raw;
        return DW'((x > 250) ? (x - 250) : 0);
`else
        return DW'(raw);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push_pixels(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            exp_q.push_back('{dat: exp_pix(i * 100), last: (i == DUM + PIX - 1)});
        end
    endtask

    task automatic wait_idle(input string name, input int limit, output int n);
        n = 0;
        while (scan_busy && n < limit) begin
            n++;
            step(1);
        end
        check({name, "_idle"}, scan_busy, 0);
    endtask

    // ADC model: busy for two cycles after each convert, result = conversion index * 100
    always @(negedge sys_clk) begin
        if (adc_convst) begin
            busy_cnt = 2;
            adc_data = DW'(conv_idx * 100);
            conv_idx = (conv_idx + 1) % (DUM + PIX);
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        adc_busy = busy_stuck || (busy_cnt > 0);
    end

    // monitor: pops the scoreboard on every accepted pixel
    always @(negedge sys_clk) begin
        exp_t e;
        cyc++;
        if (scan_done) done_cnt++;
        if (pix_valid) valid_cyc++;
        if (ccd_rog && !rog_prev) rog_edges.push_back(cyc);
        rog_prev = ccd_rog;
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got %0d expected none", pix_data);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", pix_data, e.dat);
                check("pix_last", pix_last, e.last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int v0;
        bit found;

        step(3);
        check("rst_ccd_clk", ccd_clk, 1);
        check("rst_ccd_rog", ccd_rog, 0);
        check("rst_convst", adc_convst, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_last", pix_last, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_scan_busy", scan_busy, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_overrun", overrun, 0);
        sys_rst = 1'b0;
        step(2);

        // single scan, sink always ready
        push_pixels(DUM, PIX);
        d0 = done_cnt;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_to_rog", ccd_rog, 1);
        check("start_busy", scan_busy, 1);
        wait_idle("single", 200, n);
        check("single_busy_cycles", n, ROGC + (DUM + PIX) * 2 * DIV);
        step(10);
        check("single_drained", exp_q.size(), 0);
        check("single_done_cnt", done_cnt - d0, 1);
        check("single_idle_clk", ccd_clk, 1);
        check("single_valid_low", pix_valid, 0);

        // continuous: ROG-to-ROG spacing includes the integration wait
        cont_en  = 1'b1;
        int_time = 16'd3;
        push_pixels(DUM, PIX);
        push_pixels(DUM, PIX);
        rog_edges.delete();
        d0 = done_cnt;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (rog_edges.size() < 2 && n < 300) begin
            n++;
            step(1);
        end
        cont_en = 1'b0;
        check("cont_rog_edges", rog_edges.size(), 2);
        if (rog_edges.size() >= 2)
            check("cont_rog_period", rog_edges[1] - rog_edges[0], ROGC + (DUM + PIX) * 2 * DIV + 3 * 2 * DIV);
        wait_idle("cont", 300, n);
        step(10);
        check("cont_drained", exp_q.size(), 0);
        check("cont_done_cnt", done_cnt - d0, 2);
        int_time = 16'd0;

        // sink stalled for the whole scan: first pixel held, the rest dropped
        pix_ready = 1'b0;
        push_pixels(DUM, 1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle("stall", 200, n);
        step(10);
        check("stall_valid", pix_valid, 1);
        check("stall_hold_data", pix_data, exp_pix(200));
        check("stall_hold_last", pix_last, 0);
        check("stall_overrun", overrun, 1);
        pix_ready = 1'b1;
        step(3);
        check("stall_drained", exp_q.size(), 0);
        check("stall_valid_after", pix_valid, 0);

        // ADC busy stuck: no pixels, overrun, scan still completes
        busy_stuck = 1'b1;
        d0 = done_cnt;
        v0 = valid_cyc;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_clears_overrun", overrun, 0);
        wait_idle("stuck", 200, n);
        step(5);
        check("stuck_done_cnt", done_cnt - d0, 1);
        check("stuck_overrun", overrun, 1);
        check("stuck_no_pixels", valid_cyc - v0, 0);
        abort      = 1'b1;
        busy_stuck = 1'b0;
        step(1);
        abort = 1'b0;
        step(5);
        check("stuck_flush_valid", pix_valid, 0);

        // abort with pixel 4 pending; start during READ ignored
        push_pixels(DUM, 4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (ccd_clk && n < 50) begin
            n++;
            step(1);
        end
        check("abort_read_reached", ccd_clk, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_in_read_rog", ccd_rog, 0);
        check("start_in_read_busy", scan_busy, 1);
        found = 1'b0;
        n = 0;
        while (!found && n < 400) begin
            if (pix_valid && pix_data == exp_pix(600)) found = 1'b1;
            else begin
                n++;
                step(1);
            end
        end
        check("abort_pixel4_seen", found, 1);
        pix_ready = 1'b0;
        abort     = 1'b1;
        d0        = done_cnt;
        step(1);
        abort = 1'b0;
        check("abort_idle", scan_busy, 0);
        check("abort_valid", pix_valid, 0);
        check("abort_ccd_clk", ccd_clk, 1);
        check("abort_ccd_rog", ccd_rog, 0);
        pix_ready = 1'b1;
        step(60);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_drained", exp_q.size(), 0);
        check("abort_no_late_pixel", pix_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_acq_seq.md
# ccd_acq_seq

Parametrised CCD acquisition sequencer for the spectrometer datapath. It generates the linear-CCD clock and ROG, and issues one ADC convert per pixel. It captures ADC results, optionally applies dark-offset subtraction and a saturation clamp, and streams pixels over a valid/ready interface into the pixel FIFO. It supersedes the fixed ILX511B/AD7621 pairing with configurable pixel count, dummy pixels, clock division and single/continuous scan modes.

## Interface
Parameters:
- DATA_W, 16, ADC/pixel word width
- PIXELS, 2048, valid pixels per scan
- DUMMY_PRE, 32, leading dummy pixels clocked out and discarded
- CLK_DIV, 4, sys_clk cycles per CCD clock half-period (≥2)
- ROG_CYCLES, 40, ROG high time in sys_clk cycles

Ports:
- sys_clk  in  1  single clock for all logic
- sys_rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle scan request
- cont_en  in  1  continuous rescanning while high
- abort  in  1  terminate the current scan
- int_time  in  16  integration wait, in CCD clock periods
- offset  in  DATA_W  dark offset
- max_sat  in  DATA_W  saturation ceiling
- ccd_clk  out  1  CCD pixel clock, idle high
- ccd_rog  out  1  readout gate, active-high (board inversion lives outside)
- adc_convst  out  1  one-cycle convert pulse
- adc_busy  in  1  ADC busy
- adc_data  in  DATA_W  ADC result
- pix_data  out  DATA_W  pixel value
- pix_last  out  1  marks pixel PIXELS-1
- pix_valid  out  1  pixel available
- pix_ready  in  1  sink accepts
- scan_busy  out  1  high in any state other than IDLE
- scan_done  out  1  one-cycle pulse at end of the READ state
- overrun  out  1  sticky flag for lost-pixel events

## Operation
- States:
  - IDLE: `start` → ROG.
  - ROG: hold `ccd_rog`=1 and `ccd_clk`=1 for ROG_CYCLES, then → READ.
  - READ: run (DUMMY_PRE+PIXELS) CCD periods, then → WAIT.
  - WAIT: hold `ccd_clk`=1 for int_time×2×CLK_DIV cycles, then → ROG if `cont_en`, else → IDLE.
- `int_time` and `cont_en` are sampled at WAIT entry. A value of 0 gives zero wait cycles.
- READ: `ccd_clk` toggles every CLK_DIV cycles, starting low. `adc_convst` pulses on the cycle `ccd_clk` rises.
- Capture `adc_data` on the first cycle `adc_busy` is seen low after being high following a convert.
- Pixel index runs from 0 to DUMMY_PRE+PIXELS-1. Indices below DUMMY_PRE are discarded.
- A convert is missed if no busy falling edge occurs before the next `adc_convst`. In that case the pixel is lost and `overrun` is set.
- Output uses a one-entry holding register:
  - Transfer occurs when `pix_valid` && `pix_ready`.
  - A capture while the register is full and not draining is dropped and sets `overrun`.
  - A capture in the same cycle as a transfer is loaded with no loss.
- `overrun` clears on an accepted `start`.
- `start` is ignored unless in IDLE.
- `abort` (or `sys_rst`) takes priority and forces IDLE on the next cycle:
  - `ccd_clk`=1, `ccd_rog`=0.
  - `pix_valid` cleared and the pending pixel discarded.
  - No `scan_done`.

## Timing
- Reset values:
  - `ccd_clk`=1.
  - `ccd_rog`, `adc_convst`, `pix_valid`, `pix_last`, `scan_busy`, `scan_done` and `overrun` are 0.
  - `pix_data`=0.
- `start` → `ccd_rog` high: 1 cycle.
- Scan length in cycles: ROG_CYCLES + (DUMMY_PRE+PIXELS)×2×CLK_DIV + int_time×2×CLK_DIV.
- Capture → `pix_valid`: 1 cycle raw, or 2 cycles with correction enabled.
- `pix_data` and `pix_last` stay stable while `pix_valid` && !`pix_ready`.

## Configuration
- `CCD_ACQ_CORR_EN` defined:
  - Clamp first: x = min(`adc_data`, `max_sat`).
  - Then subtract offset: y = x>`offset` ? x−`offset` : 0.
  - Adds one register stage.
- Undefined: `pix_data` = raw `adc_data`, and the `offset` and `max_sat` ports are ignored.

## Structure
- Shared package `ccd_acq_pkg` holds:
  - the state enum (IDLE/ROG/READ/WAIT)
  - default parameter constants
  - the pixel-index width function, clog2(DUMMY_PRE+PIXELS).
- One sub-module, `ccd_acq_adc_cap`, covers:
  - busy edge detection
  - the missed-convert check
  - the correction stage
  - the holding register.

## Test plan
Bench parameters: PIXELS=8, DUMMY_PRE=2, CLK_DIV=2, ROG_CYCLES=4.
- Single scan, ADC model returns index×100, `pix_ready`=1 → 8 pixels 200..900, `pix_last` on 900, one `scan_done`, then IDLE.
- `cont_en`=1, int_time=3 → rising edges of consecutive `ccd_rog` are 4+40+12=56 cycles apart.
- `CCD_ACQ_CORR_EN`, offset=250, max_sat=700, data 200..900 → 0,50,150,250,350,450,450,450.
- `pix_ready` held low for the whole scan → first pixel held stable, `overrun`=1, the remaining 7 pixels dropped.
- `adc_busy` stuck high → no pixels output, `overrun`=1, scan still completes with `scan_done`.
- `abort` at pixel 4 with `pix_valid` high → next cycle IDLE, `pix_valid`=0, `ccd_clk`=1, no `scan_done`; `start` during READ is ignored.
